// File: rtl/vga_timing_pkg.sv
// 640x480@60 VGA timing constants and the shared coordinate type.
// Imported by vga_sync and by the downstream pixel generator.
package vga_timing_pkg;

  localparam int unsigned COORD_W   = 32'd10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int unsigned H_DISPLAY = 32'd640;
  localparam int unsigned H_FRONT   = 32'd16;
  localparam int unsigned H_SYNC    = 32'd96;
  localparam int unsigned H_BACK    = 32'd48;
  localparam int unsigned V_DISPLAY = 32'd480;
  localparam int unsigned V_FRONT   = 32'd10;
  localparam int unsigned V_SYNC    = 32'd2;
  localparam int unsigned V_BACK    = 32'd33;

  localparam int unsigned H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // Sync windows are half-open: [START, END)
  localparam int unsigned HS_START  = H_DISPLAY + H_FRONT;
  localparam int unsigned HS_END    = H_DISPLAY + H_FRONT + H_SYNC;
  localparam int unsigned VS_START  = V_DISPLAY + V_FRONT;
  localparam int unsigned VS_END    = V_DISPLAY + V_FRONT + V_SYNC;

  function automatic logic in_window(input coord_t val, input coord_t lo, input coord_t hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/vga_sync_mod_counter.sv
// mod_counter: modulo-N up counter with enable, synchronous reset and
// a combinational terminal-count flag (high while count == N-1).
module mod_counter #(
  parameter int unsigned N = 32'd800,
  parameter int unsigned W = 32'd10
) (
  input  logic         clk_d,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(N - 32'd1);
  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_r;

  // Counter state: reset wins over enable, wrap at N-1
  always_ff @(posedge clk_d) begin
    if (reset) begin
      count_r <= {W{1'b0}};
    end else if (en) begin
      if (count_r == LAST) begin
        count_r <= {W{1'b0}};
      end else begin
        count_r <= count_r + ONE;
      end
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign tc    = (count_r == LAST);

endmodule

// File: rtl/vga_sync.sv
// vga_sync: free-running VGA raster timing generator (position, video_on, syncs).
// Optional registered frame_tick output when VGA_SYNC_FRAME_TICK_EN is defined.
module vga_sync
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int unsigned H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BACK    = vga_timing_pkg::H_BACK,
  parameter int unsigned V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int unsigned V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BACK    = vga_timing_pkg::V_BACK
) (
  input  logic       clk_d,
  input  logic       reset,
  input  logic       pix_en,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync
`ifdef VGA_SYNC_FRAME_TICK_EN
  ,
  output logic       frame_tick
`endif
);

  localparam int unsigned H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_VIS = coord_t'(H_DISPLAY);
  localparam coord_t V_VIS = coord_t'(V_DISPLAY);
  localparam coord_t HS_LO = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HS_HI = coord_t'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam coord_t VS_LO = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t VS_HI = coord_t'(V_DISPLAY + V_FRONT + V_SYNC);

  // Totals must fit the 10-bit coordinate registers
  if ((H_TOT > 32'd1024) || (V_TOT > 32'd1024)) begin : g_bad_totals
    $error("vga_sync: H_TOTAL or V_TOTAL exceeds 1024");
  end

  coord_t h_cnt_s;
  coord_t v_cnt_s;
  logic   h_tc_s;
  logic   v_tc_s;
  logic   v_en_s;

  assign v_en_s = h_tc_s & pix_en;

  mod_counter #(.N(H_TOT), .W(COORD_W)) u_h_cnt (
    .clk_d (clk_d),
    .reset (reset),
    .en    (pix_en),
    .count (h_cnt_s),
    .tc    (h_tc_s)
  );

  mod_counter #(.N(V_TOT), .W(COORD_W)) u_v_cnt (
    .clk_d (clk_d),
    .reset (reset),
    .en    (v_en_s),
    .count (v_cnt_s),
    .tc    (v_tc_s)
  );

  // Decodes are unmasked and share the counters' timing, so they stay aligned
  assign pixel_x  = h_cnt_s;
  assign pixel_y  = v_cnt_s;
  assign video_on = (h_cnt_s < H_VIS) && (v_cnt_s < V_VIS) && !reset;
  assign hsync    = !in_window(h_cnt_s, HS_LO, HS_HI);
  assign vsync    = !in_window(v_cnt_s, VS_LO, VS_HI);

`ifdef VGA_SYNC_FRAME_TICK_EN
  logic frame_tick_r;

  // Pulse lands on the cycle the counters read (0,0) after an enabled last pixel
  always_ff @(posedge clk_d) begin
    if (reset) begin
      frame_tick_r <= 1'b0;
    end else begin
      frame_tick_r <= pix_en & h_tc_s & v_tc_s;
    end
  end

  assign frame_tick = frame_tick_r;
`else
  logic unused_v_tc_s;
  assign unused_v_tc_s = v_tc_s;
`endif

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench for vga_sync: full-size instance for line-level timing and
// a shrunken-raster instance (16x12) for frame-level behaviour.
module tb_vga_sync;

`ifdef VGA_SYNC_FRAME_TICK_EN
  localparam int TICK_EN = 1;
`else
  localparam int TICK_EN = 0;
`endif

  logic       clk_d = 1'b0;
  logic       rst_a, en_a, rst_b, en_b;
  logic [9:0] x_a, y_a, x_b, y_b;
  logic       vid_a, hs_a, vs_a, ft_a;
  logic       vid_b, hs_b, vs_b, ft_b;

  int checks = 0;
  int errors = 0;

  always #5 clk_d = ~clk_d;

  vga_sync u_dut_a (
    .clk_d    (clk_d),
    .reset    (rst_a),
    .pix_en   (en_a),
    .pixel_x  (x_a),
    .pixel_y  (y_a),
    .video_on (vid_a),
    .hsync    (hs_a),
    .vsync    (vs_a)
`ifdef VGA_SYNC_FRAME_TICK_EN
    ,
    .frame_tick (ft_a)
`endif
  );

  // Small raster: H 8/2/3/3 = 16, V 6/2/2/2 = 12, frame = 192 cycles
  vga_sync #(
    .H_DISPLAY(32'd8), .H_FRONT(32'd2), .H_SYNC(32'd3), .H_BACK(32'd3),
    .V_DISPLAY(32'd6), .V_FRONT(32'd2), .V_SYNC(32'd2), .V_BACK(32'd2)
  ) u_dut_b (
    .clk_d    (clk_d),
    .reset    (rst_b),
    .pix_en   (en_b),
    .pixel_x  (x_b),
    .pixel_y  (y_b),
    .video_on (vid_b),
    .hsync    (hs_b),
    .vsync    (vs_b)
`ifdef VGA_SYNC_FRAME_TICK_EN
    ,
    .frame_tick (ft_b)
`endif
  );

`ifndef VGA_SYNC_FRAME_TICK_EN
  assign ft_a = 1'b0;
  assign ft_b = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_low, hs_bad, seq_bad, freeze_bad;
    int vid_cnt, vs_low, vs_bad, hs_low_b, tick_cnt, tick_bad;
    logic [23:0] prev;
    logic        en_was;

    rst_a = 1'b1; en_a = 1'b1; rst_b = 1'b1; en_b = 1'b1;
    repeat (3) @(negedge clk_d);

    check("rst_x", x_a, 0);
    check("rst_y", y_a, 0);
    check("rst_video_on", vid_a, 0);
    check("rst_hsync", hs_a, 1);
    check("rst_vsync", vs_a, 1);
    check("rst_frame_tick", ft_a, 0);

    rst_a = 1'b0;
    #1;
    check("release_video_on", vid_a, 1);
    check("release_pos", {x_a, y_a}, 20'd0);

    // One full line: hsync window and the x sequence
    hs_low = 0; hs_bad = 0; seq_bad = 0;
    for (int i = 0; i < 800; i++) begin
      if (x_a != 10'(i) || y_a != 10'd0) seq_bad++;
      if (!hs_a) begin
        hs_low++;
        if (x_a < 10'd656 || x_a > 10'd751) hs_bad++;
      end
      if ((x_a < 10'd640) !== vid_a) seq_bad++;
      @(negedge clk_d);
    end
    check("line_x_sequence", seq_bad, 0);
    check("line_hsync_low_cycles", hs_low, 96);
    check("line_hsync_out_of_window", hs_bad, 0);
    check("line_wrap_x", x_a, 0);
    check("line_wrap_y", y_a, 1);

    // Half-rate enable: outputs freeze on disabled cycles, line takes 1600 clocks
    freeze_bad = 0;
    for (int i = 0; i < 1600; i++) begin
      en_a   = (i % 2 == 0);
      en_was = en_a;
      prev   = {x_a, y_a, vid_a, hs_a, vs_a, 1'b0};
      @(negedge clk_d);
      if (!en_was && ({x_a, y_a, vid_a, hs_a, vs_a, 1'b0} !== prev)) freeze_bad++;
      if (i == 1597) check("halfrate_not_wrapped_y", y_a, 1);
    end
    en_a = 1'b1;
    check("halfrate_freeze", freeze_bad, 0);
    check("halfrate_line_end", {x_a, y_a}, {10'd0, 10'd2});

    // Mid-frame reset at (300,2) with pix_en high
    repeat (300) @(negedge clk_d);
    check("pre_reset_pos", {x_a, y_a}, {10'd300, 10'd2});
    check("pre_reset_video_on", vid_a, 1);
    rst_a = 1'b1;
    #1;
    check("reset_forces_video_off", vid_a, 0);
    @(negedge clk_d);
    check("midreset_pos", {x_a, y_a}, 20'd0);
    check("midreset_video_on", vid_a, 0);
    rst_a = 1'b0;
    repeat (5) @(negedge clk_d);
    check("restart_pos", {x_a, y_a}, {10'd5, 10'd0});

    // Reset beats a deasserted enable
    en_a = 1'b0; rst_a = 1'b1;
    @(negedge clk_d);
    check("reset_no_en_pos", {x_a, y_a}, 20'd0);
    rst_a = 1'b0; en_a = 1'b1;

    // Small raster: first frame after reset
    rst_b = 1'b0;
    #1;
    vid_cnt = 0; vs_low = 0; vs_bad = 0; hs_low_b = 0; tick_cnt = 0; tick_bad = 0;
    for (int i = 0; i < 192; i++) begin
      if (vid_b) vid_cnt++;
      if (!hs_b) hs_low_b++;
      if (!vs_b) begin
        vs_low++;
        if (y_b < 10'd8 || y_b > 10'd9) vs_bad++;
      end
      if (ft_b) tick_cnt++;
      @(negedge clk_d);
    end
    check("frame_video_on_cycles", vid_cnt, 48);
    check("frame_vsync_low_cycles", vs_low, 32);
    check("frame_vsync_out_of_window", vs_bad, 0);
    check("frame_hsync_low_cycles", hs_low_b, 36);
    check("first_frame_no_tick", tick_cnt, 0);
    check("frame_wrap_pos", {x_b, y_b}, 20'd0);
    check("frame_tick_at_origin", ft_b, TICK_EN);

    // Second frame: exactly one tick, only at (0,0)
    tick_cnt = 0;
    for (int i = 0; i < 192; i++) begin
      if (ft_b) begin
        tick_cnt++;
        if (x_b != 10'd0 || y_b != 10'd0) tick_bad++;
      end
      @(negedge clk_d);
    end
    check("second_frame_ticks", tick_cnt, TICK_EN);
    check("tick_position", tick_bad, 0);

    // Reset on the last pixel suppresses the tick
    repeat (191) @(negedge clk_d);
    check("last_pixel_pos", {x_b, y_b}, {10'd15, 10'd11});
    rst_b = 1'b1;
    @(negedge clk_d);
    check("reset_last_pixel_tick", ft_b, 0);
    check("reset_last_pixel_pos", {x_b, y_b}, 20'd0);
    rst_b = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
